carry_chain_seq: RTL

CARRY_CHAIN_SEQ -- requirements
Module: carry_chain_seq

---
 rtl/carry_chain_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/carry_chain_seq.sv
// Sequential adder/subtractor that resolves CHUNK bits per cycle on a shared fa_1bit chain.
// Optional signed-overflow flag is enabled by defining CARRY_CHAIN_SEQ_OVF_EN.

module fa_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g;

    assign p  = x ^ y;
    assign g  = x & y;
    assign s  = p ^ ci;
    assign co = g | (p & ci);
endmodule

module carry_chain_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_n;
    logic              carry_q, cout_q;
    logic [IW-1:0]     idx;
    logic              last;
    logic [CHUNK-1:0]  sa, sb, ss;
    logic [CHUNK:0]    c;

    assign last = (idx == IW'(N - 1));

    // Slice mux/demux by index keeps part-selects constant for every k.
    always_comb begin
        sa    = '0;
        sb    = '0;
        sum_n = sum_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                sa = a_q[k*CHUNK +: CHUNK];
                sb = b_q[k*CHUNK +: CHUNK];
                sum_n[k*CHUNK +: CHUNK] = ss;
            end
        end
    end

    assign c[0] = carry_q;
    for (genvar i = 0; i < CHUNK; i++) begin : g_chain
        fa_1bit u_fa (
            .x  (sa[i]),
            .y  (sb[i]),
            .ci (c[i]),
            .s  (ss[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge C) begin
        if (R) state <= IDLE;
        else   state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_n;
                    carry_q <= c[CHUNK];
                    if (last) cout_q <= c[CHUNK];
                    else      idx    <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CARRY_CHAIN_SEQ_OVF_EN
    logic ovf_q;

    always_ff @(posedge C) begin
        if (R)                       ovf_q <= 1'b0;
        else if (state == RUN && last) ovf_q <= c[CHUNK] ^ c[CHUNK-1];
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
